// File: rtl/ppe_rr_sched_if.sv
// Grant handshake bundle for the round-robin scheduler.
// Master offers gnt_idx under gnt_valid; slave accepts with gnt_ready.
interface ppe_rr_sched_if #(
    parameter int W = 9
);
    logic         gnt_valid;
    logic         gnt_ready;
    logic [W-1:0] gnt_idx;

    modport master (
        output gnt_valid,
        output gnt_idx,
        input  gnt_ready
    );

    modport slave (
        input  gnt_valid,
        input  gnt_idx,
        output gnt_ready
    );
endinterface

// File: rtl/ppe_rr_sched.sv
// Round-robin grant scheduler around a pipelined programmable priority encoder.
// Snapshots pending requests, waits out the PPE latency, issues one grant at a time.
module ppe_rr_sched #(
    parameter int N       = 512,
    parameter int W       = 9,
    parameter int PPE_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_set,
    output logic [N-1:0]   ppe_req,
    output logic [W-1:0]   ppe_p_enc,
    input  logic [W-1:0]   ppe_o_value,
    input  logic [W-1:0]   ppe_o_value_inc,
    input  logic           ppe_valid,
    ppe_rr_sched_if.master gnt,
    output logic [N-1:0]   pending,
    output logic           busy
);

    localparam int CW = (PPE_LAT < 1) ? 1 : $clog2(PPE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_pending;
    logic [N-1:0]  r_ppe_req;
    logic [W-1:0]  r_p_enc;
    logic [W-1:0]  r_ptr;
    logic [W-1:0]  r_nxt;
    logic [W-1:0]  r_gnt_idx;
    logic          r_gnt_valid;
    logic [CW-1:0] r_cnt;

    logic          w_hs;
    logic [N-1:0]  w_clr;

    // Only the accepted grant is retired; a same-edge req_set re-arms it.
    always_comb begin
        w_hs  = r_gnt_valid & gnt.gnt_ready;
        w_clr = '0;
        if (w_hs) w_clr[r_gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_ppe_req   <= '0;
            r_p_enc     <= '0;
            r_ptr       <= '0;
            r_nxt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | req_set;
            unique case (r_state)
                IDLE: begin
                    if (|r_pending) begin
                        r_ppe_req <= r_pending;
                        r_p_enc   <= r_ptr;
                        r_cnt     <= '0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // PPE output has settled PPE_LAT edges after the launch edge.
                    if (r_cnt == CW'(PPE_LAT)) begin
                        if (ppe_valid) begin
                            r_gnt_idx   <= ppe_o_value;
                            r_nxt       <= ppe_o_value_inc;
                            r_gnt_valid <= 1'b1;
                            r_state     <= GRANT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                GRANT: begin
                    if (w_hs) begin
                        r_ptr       <= r_nxt;
                        r_gnt_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ppe_req       = r_ppe_req;
    assign ppe_p_enc     = r_p_enc;
    assign pending       = r_pending;
    assign busy          = (r_state != IDLE);
    assign gnt.gnt_valid = r_gnt_valid;
    assign gnt.gnt_idx   = r_gnt_idx;

endmodule

// File: tb/tb_ppe_rr_sched.sv
// Directed bench for ppe_rr_sched with a 2-stage behavioural PPE model.
// Checks grant order, wrap, back-pressure, re-arm and async reset.
module tb_ppe_rr_sched;

    localparam int N   = 512;
    localparam int W   = 9;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req_set = '0;
    logic [N-1:0] ppe_req;
    logic [W-1:0] ppe_p_enc;
    logic [W-1:0] ppe_o_value;
    logic [W-1:0] ppe_o_value_inc;
    logic         ppe_valid;
    logic [N-1:0] pending;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_gnt = 0;

    ppe_rr_sched_if #(.W(W)) gif ();

    ppe_rr_sched #(.N(N), .W(W), .PPE_LAT(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_set         (req_set),
        .ppe_req         (ppe_req),
        .ppe_p_enc       (ppe_p_enc),
        .ppe_o_value     (ppe_o_value),
        .ppe_o_value_inc (ppe_o_value_inc),
        .ppe_valid       (ppe_valid),
        .gnt             (gif.master),
        .pending         (pending),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W:0] ppe_find(input logic [N-1:0] r,
                                            input logic [W-1:0] p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(p) + k) % N;
            if (r[j]) return {1'b1, W'(j)};
        end
        return '0;
    endfunction

    logic [W:0] s1 = '0;
    logic [W:0] s2 = '0;

    always @(posedge clk) begin
        s1 <= ppe_find(ppe_req, ppe_p_enc);
        s2 <= s1;
    end

    assign ppe_valid       = s2[W];
    assign ppe_o_value     = s2[W-1:0];
    assign ppe_o_value_inc = s2[W-1:0] + W'(1);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [N-1:0] v);
        req_set = v;
        tick;
        req_set = '0;
    endtask

    task automatic wait_grant(input string tag, input int exp);
        int k;
        k = 0;
        while (gif.gnt_valid !== 1'b1 && k < 20) begin
            tick;
            k++;
        end
        chk({tag, "_valid"}, N'(gif.gnt_valid), N'(1));
        chk({tag, "_idx"}, N'(gif.gnt_idx), N'(exp));
        last_gnt = cyc;
    endtask

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        int c0;
        int nv;
        logic [N-1:0] all1;
        all1 = '1;
        gif.gnt_ready = 1'b1;

        // reset state
        tick;
        tick;
        chk("rst_gv", N'(gif.gnt_valid), N'(0));
        chk("rst_idx", N'(gif.gnt_idx), N'(0));
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_pend", pending, '0);
        chk("rst_req", ppe_req, '0);
        chk("rst_penc", N'(ppe_p_enc), N'(0));
        rst = 1'b1;
        tick;

        // grants 0,2,5 in order
        pulse(bit_of(0) | bit_of(2) | bit_of(5));
        tick;
        chk("t1_req", ppe_req, bit_of(0) | bit_of(2) | bit_of(5));
        chk("t1_penc", N'(ppe_p_enc), N'(0));
        chk("t1_busy", N'(busy), N'(1));
        wait_grant("t1_g0", 0);
        c0 = last_gnt;
        tick;
        wait_grant("t1_g2", 2);
        chk("t1_gap0", N'(last_gnt - c0), N'(LAT + 3));
        c0 = last_gnt;
        tick;
        wait_grant("t1_g5", 5);
        chk("t1_gap1", N'(last_gnt - c0), N'(LAT + 3));
        tick;
        chk("t1_pend", pending, '0);
        chk("t1_busy0", N'(busy), N'(0));

        // wrap: ptr=6, bit 3
        pulse(bit_of(3));
        tick;
        chk("t2_penc", N'(ppe_p_enc), N'(6));
        wait_grant("t2_g3", 3);
        tick;

        // bit 499 from ptr=4, then all bits from ptr=500
        pulse(bit_of(499));
        tick;
        chk("t3_penc4", N'(ppe_p_enc), N'(4));
        wait_grant("t3_g499", 499);
        tick;
        pulse(all1);
        tick;
        chk("t3_penc500", N'(ppe_p_enc), N'(500));
        for (int k = 0; k < 15; k++) begin
            wait_grant("t3_all", (500 + k) % N);
            tick;
        end
        tick;
        chk("t3_penc3", N'(ppe_p_enc), N'(3));
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick;

        // back-pressure on idx 7, bit 9 arrives meanwhile
        pulse(bit_of(7));
        tick;
        chk("t4_penc", N'(ppe_p_enc), N'(0));
        gif.gnt_ready = 1'b0;
        wait_grant("t4_g7", 7);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) req_set = bit_of(9);
            tick;
            req_set = '0;
            chk("t4_hold_v", N'(gif.gnt_valid), N'(1));
            chk("t4_hold_idx", N'(gif.gnt_idx), N'(7));
            chk("t4_hold_req", ppe_req, bit_of(7));
        end
        chk("t4_pend", pending, bit_of(7) | bit_of(9));
        gif.gnt_ready = 1'b1;
        tick;
        chk("t4_pend9", pending, bit_of(9));
        wait_grant("t4_g9", 9);
        tick;

        // re-arm granted bit in the handshake cycle
        pulse(bit_of(4));
        wait_grant("t5_g4a", 4);
        req_set = bit_of(4);
        tick;
        req_set = '0;
        chk("t5_pend", pending, bit_of(4));
        wait_grant("t5_g4b", 4);
        tick;
        chk("t5_pend0", pending, '0);

        // async reset mid-WAIT (cnt=1)
        pulse(bit_of(20));
        tick;
        tick;
        chk("t6_pre_busy", N'(busy), N'(1));
        chk("t6_pre_penc", N'(ppe_p_enc), N'(5));
        rst = 1'b0;
        #1;
        chk("t6_gv", N'(gif.gnt_valid), N'(0));
        chk("t6_pend", pending, '0);
        chk("t6_penc", N'(ppe_p_enc), N'(0));
        chk("t6_busy", N'(busy), N'(0));
        chk("t6_req", ppe_req, '0);
        tick;
        rst = 1'b1;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (gif.gnt_valid === 1'b1) nv++;
        end
        chk("t6_nogrant", N'(nv), N'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
